// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package : mem_arb_pkg
// Shared FSM state encoding, grant codes and defaults for mem_port_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_CPU  = 2'b01;
    localparam logic [1:0] GNT_DBG  = 2'b10;

    localparam int DEFAULT_TIMEOUT = 15;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : mem_port_arbiter_if
// Requester (CPU, DBG) and memory-port signals of the memory port arbiter.
// Rev       : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic              cpu_err;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic              dbg_err;
    logic [DATA_W-1:0] dbg_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic [1:0]        grant;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_err, cpu_rdata, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_err, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output grant
    );

    // Requesters plus memory model side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_err, cpu_rdata, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_err, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  grant
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter2
// Combinational two-way round-robin winner select (CPU vs DBG).
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  wire logic       i_cpu_req,
    input  wire logic       i_dbg_req,
    input  wire logic [1:0] i_last_grant,
    output logic      [1:0] o_winner
);
    always_comb begin
        o_winner = GNT_NONE;
        if (i_cpu_req && i_dbg_req) begin
            // On a tie the requester that was not served last wins
            o_winner = (i_last_grant == GNT_CPU) ? GNT_DBG : GNT_CPU;
        end else if (i_cpu_req) begin
            o_winner = GNT_CPU;
        end else if (i_dbg_req) begin
            o_winner = GNT_DBG;
        end
    end
endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter
// Serialises CPU and DBG accesses onto one memory port with timeout abort.
// Rev    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mem_port_arbiter_if.slave bus
);
    localparam int c_cnt_w = $clog2(TIMEOUT + 1);

    arb_state_t         state_q,      state_d;
    logic [1:0]         grant_q,      grant_d;
    logic [1:0]         last_grant_q, last_grant_d;
    logic [c_cnt_w-1:0] cnt_q,        cnt_d;
    logic               mem_en_q,     mem_en_d;
    logic               mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0]  addr_q,       addr_d;
    logic [DATA_W-1:0]  wdata_q,      wdata_d;
    logic               cpu_ack_q,    cpu_ack_d;
    logic               cpu_err_q,    cpu_err_d;
    logic [DATA_W-1:0]  cpu_rdata_q,  cpu_rdata_d;
    logic               dbg_ack_q,    dbg_ack_d;
    logic               dbg_err_q,    dbg_err_d;
    logic [DATA_W-1:0]  dbg_rdata_q,  dbg_rdata_d;

    logic [1:0]         w_winner;
    logic [c_cnt_w-1:0] w_cnt_inc;
    logic [DATA_W-1:0]  w_rdata;
    logic               w_done;

    rr_arbiter2 u_rr (
        .i_cpu_req    (bus.cpu_req),
        .i_dbg_req    (bus.dbg_req),
        .i_last_grant (last_grant_q),
        .o_winner     (w_winner)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cpu_ack_d    = 1'b0;
        cpu_err_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_ack_d    = 1'b0;
        dbg_err_d    = 1'b0;
        dbg_rdata_d  = dbg_rdata_q;
        w_cnt_inc    = cnt_q + c_cnt_w'(1);
        w_rdata      = (bus.mem_ready && !mem_we_q) ? bus.mem_rdata : '0;
        // A ready on the final allowed cycle still counts as success
        w_done       = bus.mem_ready || (w_cnt_inc == c_cnt_w'(TIMEOUT));

        case (state_q)
            ST_IDLE: begin
                if (w_winner != GNT_NONE) begin
                    grant_d      = w_winner;
                    last_grant_d = w_winner;
                    mem_en_d     = 1'b1;
                    state_d      = ST_ISSUE;
                    if (w_winner == GNT_CPU) begin
                        mem_we_d = bus.cpu_we;
                        addr_d   = bus.cpu_addr;
                        wdata_d  = bus.cpu_wdata;
                    end else begin
                        mem_we_d = bus.dbg_we;
                        addr_d   = bus.dbg_addr;
                        wdata_d  = bus.dbg_wdata;
                    end
                end
            end
            ST_ISSUE, ST_WAIT: begin
                if (w_done) begin
                    state_d  = ST_ACK;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    cnt_d    = '0;
                    if (grant_q == GNT_CPU) begin
                        cpu_ack_d   = 1'b1;
                        cpu_err_d   = !bus.mem_ready;
                        cpu_rdata_d = w_rdata;
                    end else begin
                        dbg_ack_d   = 1'b1;
                        dbg_err_d   = !bus.mem_ready;
                        dbg_rdata_d = w_rdata;
                    end
                end else begin
                    cnt_d   = w_cnt_inc;
                    state_d = ST_WAIT;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                grant_d = GNT_NONE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = GNT_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= GNT_NONE;
            last_grant_q <= GNT_DBG;
            cnt_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_ack_q    <= 1'b0;
            cpu_err_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_ack_q    <= 1'b0;
            dbg_err_q    <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_err_q    <= cpu_err_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_ack_q    <= dbg_ack_d;
            dbg_err_q    <= dbg_err_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_err   = cpu_err_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_q;
    assign bus.dbg_ack   = dbg_ack_q;
    assign bus.dbg_err   = dbg_err_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.grant     = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_port_arbiter
// Directed table-driven bench for mem_port_arbiter (default and TIMEOUT=3).
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    typedef struct packed {
        logic        cpu_req;
        logic        cpu_we;
        logic [31:0] cpu_addr;
        logic [31:0] cpu_wdata;
        logic        dbg_req;
        logic        dbg_we;
        logic [31:0] dbg_addr;
        logic [31:0] dbg_wdata;
        logic        mem_ready;
        logic [31:0] mem_rdata;
        logic        e_en;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [1:0]  e_gnt;
        logic        e_cack;
        logic        e_cerr;
        logic [31:0] e_crd;
        logic        e_stall;
        logic        e_dack;
        logic        e_derr;
        logic [31:0] e_drd;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_miss;
    vec_t cur;
    vec_t vecs[$];

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b  ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

    mem_port_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    mem_port_arbiter #(.TIMEOUT(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic we, input logic [1:0] gnt,
                       input logic cack, input logic cerr, input logic dack, input logic derr,
                       input logic stall, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] crd, input logic [31:0] drd);
        vec_t v;
        v         = cur;
        v.e_en    = en;
        v.e_we    = we;
        v.e_gnt   = gnt;
        v.e_cack  = cack;
        v.e_cerr  = cerr;
        v.e_dack  = dack;
        v.e_derr  = derr;
        v.e_stall = stall;
        v.e_addr  = addr;
        v.e_wdata = wdata;
        v.e_crd   = crd;
        v.e_drd   = drd;
        vecs.push_back(v);
    endtask

    // Drives one CPU read on the TIMEOUT=3 instance; ready_at=0 means never ready
    task automatic b3_txn(input logic [31:0] addr, input int ready_at, input logic [31:0] rd,
                          output int en_cyc, output logic got_ack, output logic err,
                          output logic [31:0] rdata);
        en_cyc      = 0;
        got_ack     = 1'b0;
        err         = 1'b0;
        rdata       = '0;
        b3.cpu_req  = 1'b1;
        b3.cpu_we   = 1'b0;
        b3.cpu_addr = addr;
        for (int c = 0; c < 12 && !got_ack; c++) begin
            b3.mem_ready = b3.mem_en && (en_cyc + 1 == ready_at);
            b3.mem_rdata = b3.mem_ready ? rd : 32'h0;
            @(negedge clk);
            if (b3.mem_en) en_cyc++;
            if (b3.cpu_ack) begin
                got_ack = 1'b1;
                err     = b3.cpu_err;
                rdata   = b3.cpu_rdata;
            end
            step();
        end
        b3.cpu_req   = 1'b0;
        b3.mem_ready = 1'b0;
        b3.mem_rdata = '0;
        step();
    endtask

    initial begin
        int          en_cyc;
        logic        got_ack;
        logic        err;
        logic [31:0] rdata;

        n_checks = 0;
        n_miss   = 0;
        reset    = 1'b0;
        {b.cpu_req, b.cpu_we, b.cpu_addr, b.cpu_wdata} = '0;
        {b.dbg_req, b.dbg_we, b.dbg_addr, b.dbg_wdata} = '0;
        {b.mem_ready, b.mem_rdata} = '0;
        {b3.cpu_req, b3.cpu_we, b3.cpu_addr, b3.cpu_wdata} = '0;
        {b3.dbg_req, b3.dbg_we, b3.dbg_addr, b3.dbg_wdata} = '0;
        {b3.mem_ready, b3.mem_rdata} = '0;

        // ---------------- table: tie alternation x4 from reset
        cur = '0;
        cur.cpu_req = 1'b1; cur.cpu_addr = 32'h10;
        cur.dbg_req = 1'b1; cur.dbg_addr = 32'h20;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] rd;
            rd = 32'h11 * (k + 1);
            cur.mem_ready = 1'b0; cur.mem_rdata = '0;
            add(0, 0, GNT_NONE, 0, 0, 0, 0, 1, 0, 0, 0, 0);
            cur.mem_ready = 1'b1; cur.mem_rdata = rd;
            if (k % 2 == 0) begin
                add(1, 0, GNT_CPU, 0, 0, 0, 0, 1, 32'h10, 0, 0, 0);
                cur.mem_ready = 1'b0; cur.mem_rdata = '0;
                add(0, 0, GNT_CPU, 1, 0, 0, 0, 0, 0, 0, rd, 0);
            end else begin
                add(1, 0, GNT_DBG, 0, 0, 0, 0, 1, 32'h20, 0, 0, 0);
                cur.mem_ready = 1'b0; cur.mem_rdata = '0;
                add(0, 0, GNT_DBG, 0, 0, 1, 0, 1, 0, 0, 0, rd);
            end
        end
        cur = '0;
        add(0, 0, GNT_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // ---------------- table: CPU read 0x40, ready one cycle after mem_en
        cur.cpu_req = 1'b1; cur.cpu_addr = 32'h40;
        add(0, 0, GNT_NONE, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 0, GNT_CPU,  0, 0, 0, 0, 1, 32'h40, 0, 0, 0);
        cur.mem_ready = 1'b1; cur.mem_rdata = 32'h1234_5678;
        add(1, 0, GNT_CPU,  0, 0, 0, 0, 1, 32'h40, 0, 0, 0);
        cur.mem_ready = 1'b0; cur.mem_rdata = '0;
        add(0, 0, GNT_CPU,  1, 0, 0, 0, 0, 0, 0, 32'h1234_5678, 0);
        cur.cpu_req = 1'b0;
        add(0, 0, GNT_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // ---------------- table: DBG write wins tie, both requesters drop mid-access
        cur = '0;
        cur.cpu_req = 1'b1; cur.cpu_addr = 32'h200;
        cur.dbg_req = 1'b1; cur.dbg_we = 1'b1; cur.dbg_addr = 32'h100; cur.dbg_wdata = 32'hDEAD_BEEF;
        add(0, 0, GNT_NONE, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 1, GNT_DBG,  0, 0, 0, 0, 1, 32'h100, 32'hDEAD_BEEF, 0, 0);
        cur.cpu_req = 1'b0;
        cur.dbg_req = 1'b0; cur.dbg_we = 1'b0; cur.dbg_addr = 32'h1FC; cur.dbg_wdata = '0;
        add(1, 1, GNT_DBG,  0, 0, 0, 0, 0, 32'h100, 32'hDEAD_BEEF, 0, 0);
        cur.mem_ready = 1'b1; cur.mem_rdata = 32'h5555_AAAA;
        add(1, 1, GNT_DBG,  0, 0, 0, 0, 0, 32'h100, 32'hDEAD_BEEF, 0, 0);
        cur.mem_ready = 1'b0; cur.mem_rdata = '0;
        add(0, 0, GNT_DBG,  0, 0, 1, 0, 0, 0, 0, 0, 0);
        cur.mem_ready = 1'b1; cur.mem_rdata = 32'h0BAD_0BAD;
        add(0, 0, GNT_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, GNT_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // ---------------- table: ready on the 15th (final) mem_en cycle
        cur = '0;
        cur.cpu_req = 1'b1; cur.cpu_addr = 32'h300;
        add(0, 0, GNT_NONE, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int k = 1; k < DEFAULT_TIMEOUT; k++)
            add(1, 0, GNT_CPU, 0, 0, 0, 0, 1, 32'h300, 0, 0, 0);
        cur.mem_ready = 1'b1; cur.mem_rdata = 32'hCAFE_F00D;
        add(1, 0, GNT_CPU,  0, 0, 0, 0, 1, 32'h300, 0, 0, 0);
        cur.mem_ready = 1'b0; cur.mem_rdata = '0;
        add(0, 0, GNT_CPU,  1, 0, 0, 0, 0, 0, 0, 32'hCAFE_F00D, 0);
        cur.cpu_req = 1'b0;
        add(0, 0, GNT_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // ---------------- reset state
        step();
        step();
        @(negedge clk);
        chk("rst_mem_en",  0, b.mem_en,    1'b0);
        chk("rst_mem_we",  0, b.mem_we,    1'b0);
        chk("rst_addr",    0, b.mem_addr,  32'h0);
        chk("rst_wdata",   0, b.mem_wdata, 32'h0);
        chk("rst_grant",   0, b.grant,     GNT_NONE);
        chk("rst_cpu_ack", 0, b.cpu_ack,   1'b0);
        chk("rst_dbg_ack", 0, b.dbg_ack,   1'b0);
        chk("rst_cpu_rd",  0, b.cpu_rdata, 32'h0);
        chk("rst_dbg_rd",  0, b.dbg_rdata, 32'h0);
        step();
        reset = 1'b1;

        // ---------------- apply table
        for (int i = 0; i < vecs.size(); i++) begin
            b.cpu_req   = vecs[i].cpu_req;
            b.cpu_we    = vecs[i].cpu_we;
            b.cpu_addr  = vecs[i].cpu_addr;
            b.cpu_wdata = vecs[i].cpu_wdata;
            b.dbg_req   = vecs[i].dbg_req;
            b.dbg_we    = vecs[i].dbg_we;
            b.dbg_addr  = vecs[i].dbg_addr;
            b.dbg_wdata = vecs[i].dbg_wdata;
            b.mem_ready = vecs[i].mem_ready;
            b.mem_rdata = vecs[i].mem_rdata;
            @(negedge clk);
            chk("mem_en",    i, b.mem_en,    vecs[i].e_en);
            chk("mem_we",    i, b.mem_we,    vecs[i].e_we);
            chk("grant",     i, b.grant,     vecs[i].e_gnt);
            chk("cpu_ack",   i, b.cpu_ack,   vecs[i].e_cack);
            chk("cpu_err",   i, b.cpu_err,   vecs[i].e_cerr);
            chk("cpu_stall", i, b.cpu_stall, vecs[i].e_stall);
            chk("dbg_ack",   i, b.dbg_ack,   vecs[i].e_dack);
            chk("dbg_err",   i, b.dbg_err,   vecs[i].e_derr);
            if (vecs[i].e_en) begin
                chk("mem_addr",  i, b.mem_addr,  vecs[i].e_addr);
                chk("mem_wdata", i, b.mem_wdata, vecs[i].e_wdata);
            end
            if (vecs[i].e_cack) chk("cpu_rdata", i, b.cpu_rdata, vecs[i].e_crd);
            if (vecs[i].e_dack) chk("dbg_rdata", i, b.dbg_rdata, vecs[i].e_drd);
            step();
        end
        {b.cpu_req, b.dbg_req, b.mem_ready} = '0;
        b.mem_rdata = '0;

        // ---------------- TIMEOUT=3: normal, timeout, normal
        b3_txn(32'h44, 1, 32'h77, en_cyc, got_ack, err, rdata);
        chk("t3_a_ack",   0, got_ack, 1'b1);
        chk("t3_a_en",    0, en_cyc,  32'd1);
        chk("t3_a_err",   0, err,     1'b0);
        chk("t3_a_rdata", 0, rdata,   32'h77);
        b3_txn(32'h48, 0, 32'h0, en_cyc, got_ack, err, rdata);
        chk("t3_to_ack",   1, got_ack, 1'b1);
        chk("t3_to_en",    1, en_cyc,  32'd3);
        chk("t3_to_err",   1, err,     1'b1);
        chk("t3_to_rdata", 1, rdata,   32'h0);
        b3_txn(32'h4C, 2, 32'h99, en_cyc, got_ack, err, rdata);
        chk("t3_b_ack",   2, got_ack, 1'b1);
        chk("t3_b_en",    2, en_cyc,  32'd2);
        chk("t3_b_err",   2, err,     1'b0);
        chk("t3_b_rdata", 2, rdata,   32'h99);

        // ---------------- reset pulled in WAIT, then minimum-latency read
        b.cpu_req = 1'b1; b.cpu_we = 1'b0; b.cpu_addr = 32'h80;
        step();
        step();
        @(negedge clk);
        chk("rw_wait_en", 0, b.mem_en, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        chk("rw_abort_en",    0, b.mem_en,  1'b0);
        chk("rw_abort_grant", 0, b.grant,   GNT_NONE);
        chk("rw_abort_ack",   0, b.cpu_ack, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step();
            @(negedge clk);
            chk("rw_hold_ack", k, b.cpu_ack, 1'b0);
            chk("rw_hold_en",  k, b.mem_en,  1'b0);
        end
        step();
        reset       = 1'b1;
        b.mem_ready = 1'b1;
        b.mem_rdata = 32'hBEEF_0001;
        @(negedge clk);
        chk("rw_c0_en",  0, b.mem_en,  1'b0);
        step();
        @(negedge clk);
        chk("rw_c1_en",    1, b.mem_en,   1'b1);
        chk("rw_c1_grant", 1, b.grant,    GNT_CPU);
        chk("rw_c1_addr",  1, b.mem_addr, 32'h80);
        step();
        b.mem_ready = 1'b0;
        b.mem_rdata = '0;
        @(negedge clk);
        chk("rw_c2_ack",   2, b.cpu_ack,   1'b1);
        chk("rw_c2_err",   2, b.cpu_err,   1'b0);
        chk("rw_c2_rdata", 2, b.cpu_rdata, 32'hBEEF_0001);
        step();
        b.cpu_req = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and transaction sequencer for the single Stage1 cache/memory port. It shares the port between the CPU datapath (fetch, load, store under Controller_FSM) and a debug/loader requester used for program load and memory inspection. It serialises accesses, holds `mem_en` until the memory signals ready, and reports completion and timeout errors back to each requester. It also produces a stall indication for the controller FSM.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 15, maximum `mem_en` cycles without `mem_ready` before abort; minimum 1
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `cpu_req`, `cpu_we`  in  1  CPU request and write enable; held stable until `cpu_ack`
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU write data
- `cpu_ack`, `cpu_err`  out  1  one-cycle completion pulse and timeout flag
- `cpu_rdata`  out  DATA_W  registered read data, valid while `cpu_ack`=1
- `cpu_stall`  out  1  `cpu_req & ~cpu_ack`
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_ack`, `dbg_err`, `dbg_rdata`: same meaning and widths as the CPU set
- `mem_en`, `mem_we`  out  1  memory access strobe and write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid with `mem_ready`
- `mem_ready`  in  1  access complete, sampled while `mem_en`=1
- `grant`  out  2  00 none, 01 CPU, 10 DBG (registered owner)

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK.
- **IDLE**
  - Sample `cpu_req`/`dbg_req`. No request: stay.
  - One request: grant it, latch its `we`/`addr`/`wdata` into the command register, go to ISSUE.
  - Both requests: round-robin. Grant the requester not in `last_grant`, then update `last_grant`.
- **ISSUE / WAIT**
  - `mem_en`=1; `mem_we`, `mem_addr`, `mem_wdata` come from the command register.
  - `mem_ready`=1: capture `mem_rdata` (reads only; writes return 0), go to ACK.
  - Otherwise increment the wait counter. When the counter reaches TIMEOUT, set the error flag and go to ACK with rdata = 0.
  - ISSUE moves to WAIT after one cycle.
- **ACK**
  - Pulse the granted requester's `ack` (and `err` if timed out) for exactly one cycle.
  - `mem_en`=0; clear the counter; `grant` returns to 00 on entering IDLE.
- Command register isolation: requester inputs are ignored after the grant. A requester that changes or drops `req` mid-transaction still receives `ack`.
- The non-granted requester waits with `req` held. Its `ack` stays 0.
- `last_grant` resets to DBG, so the CPU wins the first tie. Neither requester waits more than one foreign transaction.

## Timing
- Reset (async, active-low) values:
  - FSM = IDLE; `grant`=00; `last_grant`=DBG; counter = 0.
  - All `ack`/`err`/`mem_en`/`mem_we` = 0; all data/address outputs = 0.
- Reset asserted mid-transaction aborts immediately. No `ack` is produced and `mem_en` drops asynchronously.
- Minimum latency: `req` in cycle 0 → `mem_en` cycle 1 → `mem_ready` cycle 1 → `ack` cycle 2.
- General case: `mem_ready` in cycle k → `ack` in cycle k+1.
- Back-to-back: the cycle after `ack` is IDLE. A still-asserted `req` there is treated as a new request, so one idle port cycle separates transactions.
- Timeout: `mem_en` high for TIMEOUT cycles with no `mem_ready` → `ack`+`err` in the next cycle.
- `mem_ready` coinciding with the final timeout cycle counts as success; `err`=0.
- `mem_ready` while `mem_en`=0 is ignored.

## Structure
- Shared package `mem_arb_pkg`:
  - FSM state enum
  - grant encoding constants `GNT_NONE`/`GNT_CPU`/`GNT_DBG`
  - default `TIMEOUT`
- One sub-module, `rr_arbiter2`: combinational winner select from two requests plus `last_grant`.
- The FSM, counter and command register stay in `mem_port_arbiter`.

## Test plan
- CPU read, addr 0x0000_0040, `mem_ready` one cycle after `mem_en`, rdata 0x1234_5678 → `cpu_ack` in cycle 3, `cpu_rdata`=0x1234_5678, `grant`=01 during access, `dbg_ack` stays 0.
- Simultaneous `cpu_req` and `dbg_req` from reset → CPU served first, DBG granted in the IDLE after `cpu_ack`. Repeat ×4 with both held → grants alternate 01,10,01,10.
- DBG write 0xDEAD_BEEF to 0x100, CPU drops `cpu_req` mid-DBG access → `mem_we`=1 with correct data. CPU gets no grant and `cpu_stall` returns to 0.
- TIMEOUT=3, `mem_ready` never asserted → `mem_en` high exactly 3 cycles, then `cpu_ack`=`cpu_err`=1, rdata 0. Next request completes normally.
- Reset pulled low in WAIT → `mem_en`, `grant`, `ack` go 0 immediately. After release, a new CPU read completes with 2-cycle minimum latency.
- `mem_ready` on the 15th (final) cycle with default TIMEOUT → `ack`=1, `err`=0, data captured.
